// File: rtl/alu_issue_queue_if.sv
// Bus bundle for alu_issue_queue: request channel, ALU drive/return,
// result channel and occupancy. The DUT uses the slave view and the
// surrounding logic (or bench) uses the master view.
interface alu_issue_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_opA;
    logic [DATA_W-1:0] in_opB;
    logic [OP_W-1:0]   in_op;

    logic [DATA_W-1:0] alu_operandA;
    logic [DATA_W-1:0] alu_operandB;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [OP_W-1:0]   out_op;
    logic              out_undef;

    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_opA, in_opB, in_op, alu_result, out_ready,
        output in_ready, alu_operandA, alu_operandB, alu_op,
               out_valid, out_result, out_op, out_undef, count
    );

    modport master (
        output in_valid, in_opA, in_opB, in_op, alu_result, out_ready,
        input  in_ready, alu_operandA, alu_operandB, alu_op,
               out_valid, out_result, out_op, out_undef, count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue/retire wrapper around an external combinational 4-bit ALU.
// Requests are queued in a DEPTH-entry FIFO; the head entry drives the ALU
// from flops, and the ALU result is captured into a one-entry output slot.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * DATA_W + OP_W;
    localparam logic [OP_W-1:0] OP_IDLE    = '1;
    localparam logic [OP_W-1:0] OP_LAST_OK = OP_W'(4);

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic              out_undef_q, out_undef_d;

    logic              full, empty, push, pop;
    logic [ENT_W-1:0]  head;
    logic [DATA_W-1:0] head_a, head_b;
    logic [OP_W-1:0]   head_op;

    // Full blocks pushes even when a pop happens the same cycle (no bypass).
    assign full          = (count_q == CNT_W'(DEPTH));
    assign empty         = (count_q == '0);
    assign bus.in_ready  = !rst && !full;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = !empty && (!out_valid_q || bus.out_ready);

    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[OP_W-1:0];
    assign head_b  = head[OP_W +: DATA_W];
    assign head_a  = head[OP_W+DATA_W +: DATA_W];

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_op     = out_op_q;
    assign bus.out_undef  = out_undef_q;
    assign bus.count      = count_q;

    // ALU operands come only from queue storage; an idle op is parked when empty.
    always_comb begin
        bus.alu_operandA = '0;
        bus.alu_operandB = '0;
        bus.alu_op       = OP_IDLE;
        if (!empty) begin
            bus.alu_operandA = head_a;
            bus.alu_operandB = head_b;
            bus.alu_op       = head_op;
        end
    end

    // Next-state for pointers, occupancy, storage and the output slot.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_undef_d  = out_undef_q;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_opA, bus.in_opB, bus.in_op};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = bus.alu_result;
            out_op_d     = head_op;
            out_undef_d  = (head_op > OP_LAST_OK);
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control and output-slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= '0;
            out_undef_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_undef_q  <= out_undef_d;
        end
    end

    // Queue storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural 4-bit ALU attached.
module tb_alu_issue_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            default: return 4'h0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_f(bus.alu_operandA, bus.alu_operandB, bus.alu_op);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       undef;
    } vec_t;

    vec_t single_v[10];
    vec_t stream_v[5];
    vec_t bp_v[6];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_opA   = v.a;
        bus.in_opB   = v.b;
        bus.in_op    = v.op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        int   first_cyc;
        int   last_cyc;
        logic acc;

        single_v[0] = '{4'h9, 4'h8, 3'b000, 4'h1, 1'b0};
        single_v[1] = '{4'h2, 4'h5, 3'b001, 4'hD, 1'b0};
        single_v[2] = '{4'hC, 4'hA, 3'b010, 4'h8, 1'b0};
        single_v[3] = '{4'h1, 4'h8, 3'b011, 4'h9, 1'b0};
        single_v[4] = '{4'hF, 4'h5, 3'b100, 4'hA, 1'b0};
        single_v[5] = '{4'hF, 4'hF, 3'b110, 4'h0, 1'b1};
        single_v[6] = '{4'h7, 4'h3, 3'b101, 4'h0, 1'b1};
        single_v[7] = '{4'h4, 4'h4, 3'b111, 4'h0, 1'b1};
        single_v[8] = '{4'hF, 4'h1, 3'b000, 4'h0, 1'b0};
        single_v[9] = '{4'h0, 4'h1, 3'b001, 4'hF, 1'b0};

        stream_v[0] = '{4'h3, 4'h4, 3'b000, 4'h7, 1'b0};
        stream_v[1] = '{4'h2, 4'h5, 3'b001, 4'hD, 1'b0};
        stream_v[2] = '{4'hC, 4'hA, 3'b010, 4'h8, 1'b0};
        stream_v[3] = '{4'h1, 4'h8, 3'b011, 4'h9, 1'b0};
        stream_v[4] = '{4'hF, 4'h5, 3'b100, 4'hA, 1'b0};

        bp_v[0] = '{4'h1, 4'h1, 3'b000, 4'h2, 1'b0};
        bp_v[1] = '{4'h9, 4'h3, 3'b001, 4'h6, 1'b0};
        bp_v[2] = '{4'hB, 4'hE, 3'b010, 4'hA, 1'b0};
        bp_v[3] = '{4'h4, 4'h1, 3'b011, 4'h5, 1'b0};
        bp_v[4] = '{4'h7, 4'h4, 3'b100, 4'h3, 1'b0};
        bp_v[5] = '{4'h6, 4'h8, 3'b000, 4'hE, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_opA    = '0;
        bus.in_opB    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;

        // reset held for two edges
        step();
        chk("rst_in_ready_during", bus.in_ready, 0);
        step();
        chk("rst_in_ready_during2", bus.in_ready, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_alu_op_idle", bus.alu_op, 3'b111);
        chk("rst_alu_opA_idle", bus.alu_operandA, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", bus.in_ready, 1);

        // single requests, one at a time
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(single_v[i]);
            step();
            bus.in_valid = 1'b0;
            chk("single_early_valid", bus.out_valid, 0);
            chk("single_count1", bus.count, 1);
            step();
            chk("single_valid", bus.out_valid, 1);
            chk("single_result", bus.out_result, single_v[i].res);
            chk("single_op", bus.out_op, single_v[i].op);
            chk("single_undef", bus.out_undef, single_v[i].undef);
            step();
            chk("single_drained", bus.out_valid, 0);
            chk("single_count0", bus.count, 0);
        end

        // back-to-back stream with consumer always ready
        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 5) drive(stream_v[cyc]);
            else         bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                if (got < 5) chk("stream_result", bus.out_result, stream_v[got].res);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            step();
        end
        chk("stream_count", got, 5);
        chk("stream_first_cyc", first_cyc, 2);
        chk("stream_last_cyc", last_cyc, 6);

        // backpressure: consumer stalled while six requests are offered
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(bp_v[i]);
            chk("bp_in_ready", bus.in_ready, 1);
            step();
        end
        drive(bp_v[5]);
        step();
        chk("bp_hold_result1", bus.out_result, bp_v[0].res);
        step();
        chk("bp_full_in_ready", bus.in_ready, 0);
        chk("bp_full_count", bus.count, 4);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_result2", bus.out_result, bp_v[0].res);
        chk("bp_hold_op", bus.out_op, bp_v[0].op);
        bus.out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            if (bus.out_valid) begin
                chk("bp_result", bus.out_result, bp_v[got].res);
                chk("bp_op", bus.out_op, bp_v[got].op);
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) bus.in_valid = 1'b0;
        end
        chk("bp_all_out", got, 6);
        chk("bp_in_valid_taken", bus.in_valid, 0);
        step();
        chk("bp_final_count", bus.count, 0);
        chk("bp_final_valid", bus.out_valid, 0);

        // reset in the middle of traffic
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(bp_v[i]);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_count3", bus.count, 3);
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_result", bus.out_result, bp_v[0].res);
        rst = 1'b1;
        step();
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_stale", bus.out_valid, 0);
        end
        drive(single_v[0]);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_result", bus.out_result, single_v[0].res);
        step();
        chk("post_rst_drained", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
